// File: rtl/yarvi_uart_pkg.sv
// Shared UART definitions: frame FSM states, data width and default bit divisor.
// Common to the transmitter and the future receiver.
package yarvi_uart_pkg;

  localparam int UART_DATA_BITS        = 8;
  localparam int UART_BAUD_DIV_DEFAULT = 434;  // 50 MHz / 115200

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

endpackage

// File: rtl/yarvi_sync_fifo.sv
// Single-clock FIFO, data visible at pop_data one cycle after push; full/empty come from a
// registered count, so a pop never combinationally reopens the push side.
module yarvi_sync_fifo #(
  parameter int WIDTH      = 8,
  parameter int LOG2_DEPTH = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int DEPTH = 1 << LOG2_DEPTH;

  logic [WIDTH-1:0]      mem_q [DEPTH];
  logic [WIDTH-1:0]      mem_d [DEPTH];
  logic [LOG2_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [LOG2_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [LOG2_DEPTH:0]   count_q, count_d;
  logic                  do_push, do_pop;

  assign full     = (count_q == (LOG2_DEPTH+1)'(DEPTH));
  assign empty    = (count_q == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem_q[rd_ptr_q];

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    // Simultaneous push and pop leaves the occupancy unchanged.
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock) begin
    mem_q <= mem_d;
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/yarvi_uart_tx.sv
// 8N1 UART transmitter: bytes queue in a small FIFO, first start bit drives txd two edges
// after acceptance; in_ready drops only while the FIFO is full.
module yarvi_uart_tx
  import yarvi_uart_pkg::*;
#(
  parameter int BAUD_DIV  = UART_BAUD_DIV_DEFAULT,
  parameter int FIFO_LOG2 = 2
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  output logic       in_ready,
  output logic       txd,
  output logic       busy
);

  localparam int                 CNT_W    = $clog2(BAUD_DIV);
  localparam int                 IDX_W    = $clog2(UART_DATA_BITS);
  localparam logic [CNT_W-1:0]   RELOAD   = CNT_W'(BAUD_DIV - 1);
  localparam logic [IDX_W-1:0]   LAST_IDX = IDX_W'(UART_DATA_BITS - 1);

  uart_state_e                 state_q, state_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]            idx_q, idx_d;
  logic [UART_DATA_BITS-1:0]   shift_q, shift_d;
  logic                        txd_q, txd_d;
  logic                        busy_q, busy_d;

  logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
  logic [UART_DATA_BITS-1:0]   fifo_data;

  assign in_ready  = !fifo_full;
  assign fifo_push = in_valid && in_ready;
  assign txd       = txd_q;
  assign busy      = busy_q;

  yarvi_sync_fifo #(
    .WIDTH      (UART_DATA_BITS),
    .LOG2_DEPTH (FIFO_LOG2)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .push      (fifo_push),
    .push_data (in_data),
    .pop       (fifo_pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    idx_d    = idx_q;
    shift_d  = shift_q;
    fifo_pop = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          shift_d  = fifo_data;
          cnt_d    = RELOAD;
          state_d  = START;
        end
      end
      START: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          idx_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DATA: begin
        if (cnt_q == '0) begin
          cnt_d   = RELOAD;
          shift_d = {1'b0, shift_q[UART_DATA_BITS-1:1]};
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      STOP: begin
        // Chain straight into the next start bit so back-to-back frames have no idle gap.
        if (cnt_q == '0) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            shift_d  = fifo_data;
            cnt_d    = RELOAD;
            state_d  = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    // txd is registered from the next state so the line level and the FSM stay aligned.
    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase

    busy_d = (state_q != IDLE) || !fifo_empty;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      txd_q   <= 1'b1;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      txd_q   <= txd_d;
      busy_q  <= busy_d;
    end
  end

endmodule

// File: tb/tb_yarvi_uart_tx.sv
// Directed bench for yarvi_uart_tx: a BAUD_DIV=4 instance decoded by a frame monitor against
// a byte scoreboard, plus a BAUD_DIV=2 instance checked cycle by cycle.
module tb_yarvi_uart_tx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       in_vld4 = 1'b0;
  logic [7:0] in_dat4 = 8'h00;
  logic       in_rdy4, txd4, busy4;

  logic       in_vld2 = 1'b0;
  logic [7:0] in_dat2 = 8'h00;
  logic       in_rdy2, txd2, busy2;

  int         compared   = 0;
  int         mismatched = 0;
  int         cyc        = 0;
  int         gen        = 0;
  bit         mon_busy   = 1'b0;
  int         acc_cyc    = 0;
  logic [7:0] exp_q[$];
  int         start_q[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  yarvi_uart_tx #(.BAUD_DIV(4), .FIFO_LOG2(2)) dut4 (
    .clock    (clk),
    .reset    (rst),
    .in_valid (in_vld4),
    .in_data  (in_dat4),
    .in_ready (in_rdy4),
    .txd      (txd4),
    .busy     (busy4)
  );

  yarvi_uart_tx #(.BAUD_DIV(2), .FIFO_LOG2(2)) dut2 (
    .clock    (clk),
    .reset    (rst),
    .in_valid (in_vld2),
    .in_data  (in_dat2),
    .in_ready (in_rdy2),
    .txd      (txd2),
    .busy     (busy2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    compared++;
    assert (obs === expv) else begin
      mismatched++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  // Hold one byte on the selected producer port until it is accepted.
  task automatic push(input bit on2, input logic [7:0] b, input bit keep);
    int n = 0;
    @(negedge clk);
    if (on2) begin in_vld2 = 1'b1; in_dat2 = b; end
    else     begin in_vld4 = 1'b1; in_dat4 = b; end
    while (((on2 ? in_rdy2 : in_rdy4) !== 1'b1) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("push_wait", 32'(n < 2000), 32'd1);
    @(posedge clk);
    if (!on2) exp_q.push_back(b);
    #1;
    acc_cyc = cyc;
    if (!keep) begin
      in_vld4 = 1'b0;
      in_vld2 = 1'b0;
    end
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((exp_q.size() != 0 || mon_busy) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("drain_wait", 32'(n < budget), 32'd1);
  endtask

  // Frame decoder for the BAUD_DIV=4 instance: samples each bit in its middle cycle.
  initial begin : monitor
    logic [7:0] byt;
    logic       s_ok, p_ok;
    int         g;
    forever begin
      @(negedge clk);
      if (!rst && txd4 === 1'b0) begin
        mon_busy = 1'b1;
        g = gen;
        start_q.push_back(cyc);
        repeat (2) @(negedge clk);
        s_ok = (txd4 === 1'b0);
        for (int i = 0; i < 8; i++) begin
          repeat (4) @(negedge clk);
          byt[i] = txd4;
        end
        repeat (4) @(negedge clk);
        p_ok = (txd4 === 1'b1);
        if (g == gen) begin
          check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
          if (exp_q.size() != 0) check("frame_byte", 32'(byt), 32'(exp_q.pop_front()));
          check("start_bit", 32'(s_ok), 32'd1);
          check("stop_bit", 32'(p_ok), 32'd1);
        end
        mon_busy = 1'b0;
      end
    end
  end

  initial begin : stimulus
    int t0;
    int s;
    int n;

    // Reset values, then idle.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_txd", 32'(txd4), 32'd1);
    check("rst_busy", 32'(busy4), 32'd0);
    check("rst_rdy", 32'(in_rdy4), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("idle_txd", 32'(txd4), 32'd1);
      check("idle_busy", 32'(busy4), 32'd0);
      check("idle_rdy", 32'(in_rdy4), 32'd1);
    end

    // Single 0x55 frame, cycle exact.
    push(1'b0, 8'h55, 1'b0);
    @(negedge clk);
    check("txd_before_pop", 32'(txd4), 32'd1);
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      check("frame55_txd", 32'(txd4), 32'((j / 4) % 2));
      check("frame55_busy", 32'(busy4), 32'd1);
    end
    @(negedge clk);
    check("post55_txd", 32'(txd4), 32'd1);
    check("post55_busy_hold", 32'(busy4), 32'd1);
    @(negedge clk);
    check("post55_busy_fall", 32'(busy4), 32'd0);
    drain(200);

    // Back-to-back 0xA3, 0x0F with in_valid held.
    start_q.delete();
    push(1'b0, 8'hA3, 1'b1);
    push(1'b0, 8'h0F, 1'b0);
    drain(400);
    check("b2b_frames", 32'(start_q.size()), 32'd2);
    if (start_q.size() == 2) check("b2b_gap", 32'(start_q[1] - start_q[0]), 32'd40);

    // Six bytes into a four-entry FIFO.
    push(1'b0, 8'h11, 1'b1);
    t0 = acc_cyc;
    push(1'b0, 8'h22, 1'b1);
    push(1'b0, 8'h80, 1'b1);
    push(1'b0, 8'h01, 1'b1);
    push(1'b0, 8'hC5, 1'b1);
    @(negedge clk);
    check("rdy_full", 32'(in_rdy4), 32'd0);
    push(1'b0, 8'h3E, 1'b0);
    check("sixth_accept_cycle", 32'(acc_cyc - t0), 32'd42);
    drain(600);

    // Reset in DATA bit 3 of 0xFF with two bytes queued.
    start_q.delete();
    push(1'b0, 8'hFF, 1'b1);
    push(1'b0, 8'h12, 1'b1);
    push(1'b0, 8'h34, 1'b0);
    n = 0;
    while (start_q.size() == 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ff_start_seen", 32'(start_q.size() != 0), 32'd1);
    s = (start_q.size() != 0) ? start_q[0] : cyc;
    n = 0;
    while (cyc < s + 17 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("ff_bit3_txd", 32'(txd4), 32'd1);
    check("ff_bit3_busy", 32'(busy4), 32'd1);
    rst = 1'b1;
    @(posedge clk);
    gen++;
    exp_q.delete();
    @(negedge clk);
    check("midrst_txd", 32'(txd4), 32'd1);
    check("midrst_busy", 32'(busy4), 32'd0);
    check("midrst_rdy", 32'(in_rdy4), 32'd1);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("postrst_txd", 32'(txd4), 32'd1);
      check("postrst_busy", 32'(busy4), 32'd0);
    end
    drain(100);

    // Minimum divisor with 0x00.
    push(1'b1, 8'h00, 1'b0);
    @(negedge clk);
    check("div2_pre_txd", 32'(txd2), 32'd1);
    for (int j = 0; j < 20; j++) begin
      @(negedge clk);
      check("div2_txd", 32'(txd2), 32'(j >= 18));
    end
    @(negedge clk);
    check("div2_idle_txd", 32'(txd2), 32'd1);
    check("div2_busy_hold", 32'(busy2), 32'd1);
    @(negedge clk);
    check("div2_busy_fall", 32'(busy2), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
